// File: rtl/lc3b_dual_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lc3b_types (package)
// Brief   : Shared LC-3b word/mask types plus the memory-responder FSM state
//           enum, latency-counter width and byte-merge helper.
// Revision: 1.0 - initial release
// ============================================================================
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lc3b_memresp_state;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int LC3B_MEM_LAT_W = 4;

  // Byte-lane merge: lanes with a set mask bit take the new data.
  function automatic lc3b_word lc3b_merge_bytes(lc3b_word old_w, lc3b_word new_w,
                                                lc3b_mem_wmask mask);
    lc3b_word res;
    res = old_w;
    if (mask[0]) res[7:0]  = new_w[7:0];
    if (mask[1]) res[15:8] = new_w[15:8];
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lc3b_dual_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : lc3b_dual_mem_responder_if
// Brief   : One CPU memory port: read/write/byte-enable request handshake
//           with a single-cycle completion pulse and read data.
// Revision: 1.0 - initial release
// ============================================================================
interface lc3b_dual_mem_responder_if;
  import lc3b_types::*;

  logic          mem_read;
  logic          mem_write;
  lc3b_mem_wmask mem_byte_enable;
  lc3b_word      mem_address;
  lc3b_word      mem_wdata;
  logic          mem_resp;
  lc3b_word      mem_rdata;

  // CPU side issues requests
  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata
  );

  // Memory side answers them
  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/lc3b_dual_mem_responder_mem_port_fsm.sv
`default_nettype none
// ============================================================================
// Module  : lc3b_mem_port_fsm
// Brief   : Per-port request sequencer. Accepts a request in IDLE, waits
//           LATENCY-1 cycles, pulses resp for one cycle. Emits a commit
//           strobe in the cycle whose closing edge enters RESP, together
//           with the request fields the array should act on at that edge.
// Revision: 1.0 - initial release
// ============================================================================
module lc3b_mem_port_fsm
  import lc3b_types::*;
#(
  parameter int LATENCY = 3
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          i_read,
  input  wire logic          i_write,
  input  wire lc3b_mem_wmask i_wmask,
  input  wire lc3b_word      i_addr,
  input  wire lc3b_word      i_wdata,
  output logic               o_resp,
  output logic               o_commit,
  output logic               o_is_write,
  output lc3b_mem_wmask      o_wmask,
  output lc3b_word           o_addr,
  output lc3b_word           o_wdata
);

  localparam logic [LC3B_MEM_LAT_W-1:0] C_CNT_LOAD = LC3B_MEM_LAT_W'(LATENCY - 1);
  localparam logic [LC3B_MEM_LAT_W-1:0] C_CNT_ONE  = LC3B_MEM_LAT_W'(1);

  lc3b_memresp_state           r_state;
  lc3b_memresp_state           w_state_nxt;
  logic [LC3B_MEM_LAT_W-1:0]   r_cnt;
  logic [LC3B_MEM_LAT_W-1:0]   w_cnt_nxt;
  logic                        w_req;
  logic                        w_accept;
  logic                        r_is_write;
  lc3b_mem_wmask               r_wmask;
  lc3b_word                    r_addr;
  lc3b_word                    r_wdata;

  assign w_req = i_read | i_write;

  // State register, latency counter and the request fields captured on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_is_write <= 1'b0;
      r_wmask    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_is_write <= i_write;
        r_wmask    <= i_wmask;
        r_addr     <= i_addr;
        r_wdata    <= i_wdata;
      end
    end
  end

  // Next-state: accept in IDLE, count down in WAIT (dropping the request aborts)
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_accept  = 1'b1;
          w_cnt_nxt = C_CNT_LOAD;
          w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt <= C_CNT_ONE) begin
          w_state_nxt = RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs: registered resp, commit strobe, and the fields valid at commit.
  // In IDLE (LATENCY=1 case) the live inputs are what will be latched.
  always_comb begin
    o_resp     = (r_state == RESP);
    o_commit   = (w_state_nxt == RESP) && !reset;
    o_is_write = r_is_write;
    o_wmask    = r_wmask;
    o_addr     = r_addr;
    o_wdata    = r_wdata;
    if (r_state == IDLE) begin
      o_is_write = i_write;
      o_wmask    = i_wmask;
      o_addr     = i_addr;
      o_wdata    = i_wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lc3b_dual_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : lc3b_dual_mem_responder
// Brief   : Dual-port memory model for the pipelined LC-3b. Port a fetches,
//           port b loads/stores; both share one word array. Each port has
//           its own latency sequencer; the array, byte merging, b-over-a
//           write priority and read-data registers live here.
// Revision: 1.0 - initial release
// ============================================================================
module lc3b_dual_mem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY    = 3,
  parameter int DEPTH_LOG2 = 8
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  lc3b_dual_mem_responder_if.slave   port_a,
  lc3b_dual_mem_responder_if.slave   port_b
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  lc3b_word                 r_mem [DEPTH];
  lc3b_word                 r_rdata_a;
  lc3b_word                 r_rdata_b;

  logic                     w_resp_a,  w_resp_b;
  logic                     w_commit_a, w_commit_b;
  logic                     w_is_write_a, w_is_write_b;
  lc3b_mem_wmask            w_wmask_a, w_wmask_b;
  lc3b_word                 w_addr_a,  w_addr_b;
  lc3b_word                 w_wdata_a, w_wdata_b;
  logic [DEPTH_LOG2-1:0]    w_idx_a,   w_idx_b;
  logic                     w_wr_a,    w_wr_b;
  lc3b_word                 w_merge_a, w_base_b, w_merge_b;
  logic                     w_unused;

  lc3b_mem_port_fsm #(.LATENCY(LATENCY)) u_fsm_a (
    .clk        (clk),
    .reset      (reset),
    .i_read     (port_a.mem_read),
    .i_write    (port_a.mem_write),
    .i_wmask    (port_a.mem_byte_enable),
    .i_addr     (port_a.mem_address),
    .i_wdata    (port_a.mem_wdata),
    .o_resp     (w_resp_a),
    .o_commit   (w_commit_a),
    .o_is_write (w_is_write_a),
    .o_wmask    (w_wmask_a),
    .o_addr     (w_addr_a),
    .o_wdata    (w_wdata_a)
  );

  lc3b_mem_port_fsm #(.LATENCY(LATENCY)) u_fsm_b (
    .clk        (clk),
    .reset      (reset),
    .i_read     (port_b.mem_read),
    .i_write    (port_b.mem_write),
    .i_wmask    (port_b.mem_byte_enable),
    .i_addr     (port_b.mem_address),
    .i_wdata    (port_b.mem_wdata),
    .o_resp     (w_resp_b),
    .o_commit   (w_commit_b),
    .o_is_write (w_is_write_b),
    .o_wmask    (w_wmask_b),
    .o_addr     (w_addr_b),
    .o_wdata    (w_wdata_b)
  );

  // Byte address -> word index; upper bits alias, bit 0 is ignored
  assign w_idx_a  = w_addr_a[DEPTH_LOG2:1];
  assign w_idx_b  = w_addr_b[DEPTH_LOG2:1];
  assign w_unused = ^{w_addr_a, w_addr_b};

  assign w_wr_a = w_commit_a & w_is_write_a;
  assign w_wr_b = w_commit_b & w_is_write_b;

  // Same-word double write: b merges on top of a, so b wins overlapping lanes
  assign w_merge_a = lc3b_merge_bytes(r_mem[w_idx_a], w_wdata_a, w_wmask_a);
  assign w_base_b  = (w_wr_a && (w_idx_a == w_idx_b)) ? w_merge_a : r_mem[w_idx_b];
  assign w_merge_b = lc3b_merge_bytes(w_base_b, w_wdata_b, w_wmask_b);

  // Array update on the edge entering RESP; contents are never reset
  always_ff @(posedge clk) begin
    if (w_wr_a) r_mem[w_idx_a] <= w_merge_a;
    if (w_wr_b) r_mem[w_idx_b] <= w_merge_b;
  end

  // Read data captured on the edge entering RESP (pre-write word), held after
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      if (w_commit_a) r_rdata_a <= r_mem[w_idx_a];
      if (w_commit_b) r_rdata_b <= r_mem[w_idx_b];
    end
  end

  assign port_a.mem_resp  = w_resp_a;
  assign port_a.mem_rdata = r_rdata_a;
  assign port_b.mem_resp  = w_resp_b;
  assign port_b.mem_rdata = r_rdata_b;

endmodule
`default_nettype wire

// File: tb/tb_lc3b_dual_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_lc3b_dual_mem_responder
// Brief   : Self-checking bench: directed scenarios plus randomized dual-port
//           traffic compared against an event-scheduled reference memory.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lc3b_dual_mem_responder;

  localparam int LATENCY    = 3;
  localparam int DEPTH_LOG2 = 8;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lc3b_dual_mem_responder_if if_a ();
  lc3b_dual_mem_responder_if if_b ();

  lc3b_dual_mem_responder #(.LATENCY(LATENCY), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk    (clk),
    .reset  (reset),
    .port_a (if_a),
    .port_b (if_b)
  );

  // One outstanding request per port: when it lands and what it does
  typedef struct {
    bit          valid;
    int          commit;
    bit          rd;
    bit          wr;
    logic [1:0]  m;
    logic [15:0] addr;
    logic [15:0] data;
  } pend_t;

  pend_t       pend [2];
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] exp_rdata [2];
  int          cyc;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] o0, o1;
  int          t0, nresp, last;

  function automatic int widx(logic [15:0] a);
    return (int'(a) >> 1) % DEPTH;
  endfunction

  function automatic logic [15:0] apply_mask(logic [15:0] o, logic [15:0] n, logic [1:0] m);
    return {m[1] ? n[15:8] : o[15:8], m[0] ? n[7:0] : o[7:0]};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Reference memory: at each edge, requests scheduled to land read first,
  // then port a's write, then port b's write.
  initial begin
    cyc = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
    for (int p = 0; p < 2; p++) begin
      pend[p].valid = 1'b0;
      exp_rdata[p]  = 16'h0000;
    end
    forever begin
      @(posedge clk);
      for (int p = 0; p < 2; p++)
        if (pend[p].valid && pend[p].commit == cyc + 1)
          exp_rdata[p] = ref_mem[widx(pend[p].addr)];
      for (int p = 0; p < 2; p++)
        if (pend[p].valid && pend[p].commit == cyc + 1) begin
          if (pend[p].wr)
            ref_mem[widx(pend[p].addr)] = apply_mask(ref_mem[widx(pend[p].addr)],
                                                     pend[p].data, pend[p].m);
          pend[p].valid = 1'b0;
        end
      cyc = cyc + 1;
    end
  end

  task automatic drive(int p, bit rd, bit wr, logic [1:0] m, logic [15:0] a, logic [15:0] d);
    if (p == 0) begin
      if_a.mem_read = rd; if_a.mem_write = wr; if_a.mem_byte_enable = m;
      if_a.mem_address = a; if_a.mem_wdata = d;
    end else begin
      if_b.mem_read = rd; if_b.mem_write = wr; if_b.mem_byte_enable = m;
      if_b.mem_address = a; if_b.mem_wdata = d;
    end
  endtask

  function automatic logic resp_of(int p);
    return (p == 0) ? if_a.mem_resp : if_b.mem_resp;
  endfunction

  function automatic logic [15:0] rdata_of(int p);
    return (p == 0) ? if_a.mem_rdata : if_b.mem_rdata;
  endfunction

  // Called at a negedge with the port idle; the next edge accepts it
  task automatic start_req(int p, bit rd, bit wr, logic [1:0] m, logic [15:0] a, logic [15:0] d);
    drive(p, rd, wr, m, a, d);
    pend[p].rd     = rd;
    pend[p].wr     = wr;
    pend[p].m      = m;
    pend[p].addr   = a;
    pend[p].data   = d;
    pend[p].commit = cyc + LATENCY;
    pend[p].valid  = 1'b1;
  endtask

  task automatic finish_req(int p, output logic [15:0] obs);
    bit rd;
    rd = pend[p].rd;
    for (int k = 1; k <= LATENCY; k++) begin
      @(negedge clk);
      if (k < LATENCY) check($sformatf("p%0d_early_resp", p), 32'(resp_of(p)), 32'd0);
    end
    check($sformatf("p%0d_resp_latency", p), 32'(resp_of(p)), 32'd1);
    obs = rdata_of(p);
    if (rd) check($sformatf("p%0d_rdata", p), 32'(obs), 32'(exp_rdata[p]));
    drive(p, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    @(negedge clk);
    check($sformatf("p%0d_resp_pulse", p), 32'(resp_of(p)), 32'd0);
  endtask

  task automatic do_req(int p, bit rd, bit wr, logic [1:0] m, logic [15:0] a, logic [15:0] d,
                        output logic [15:0] obs);
    start_req(p, rd, wr, m, a, d);
    finish_req(p, obs);
  endtask

  task automatic rand_op(int p);
    int          op;
    logic [15:0] a;
    logic [15:0] obs;
    op = $urandom_range(0, 3);
    a  = 16'($urandom);
    a[8:1] = 8'($urandom_range(0, 7));
    repeat ($urandom_range(0, 2)) @(negedge clk);
    if (op != 3)
      do_req(p, (op == 0 || op == 2), (op == 1 || op == 2), 2'($urandom), a,
             16'($urandom), obs);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    drive(1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_resp_a",  32'(if_a.mem_resp),  32'd0);
    check("rst_resp_b",  32'(if_b.mem_resp),  32'd0);
    check("rst_rdata_a", 32'(if_a.mem_rdata), 32'd0);
    check("rst_rdata_b", 32'(if_b.mem_rdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Read of never-written memory
    do_req(0, 1, 0, 2'b00, 16'h0010, 16'h0000, o0);
    check("read_zero", 32'(o0), 32'h0000);

    // Store on b visible to fetch on a, then partial-byte stores
    do_req(1, 0, 1, 2'b11, 16'h0020, 16'hBEEF, o1);
    do_req(0, 1, 0, 2'b00, 16'h0020, 16'h0000, o0);
    check("full_write", 32'(o0), 32'hBEEF);
    do_req(1, 0, 1, 2'b01, 16'h0020, 16'h12CD, o1);
    do_req(0, 1, 0, 2'b00, 16'h0020, 16'h0000, o0);
    check("low_byte_write", 32'(o0), 32'hBECD);
    do_req(1, 0, 1, 2'b10, 16'h0020, 16'h5500, o1);
    do_req(0, 1, 0, 2'b00, 16'h0020, 16'h0000, o0);
    check("high_byte_write", 32'(o0), 32'h55CD);

    // Same-edge a read / b write to one word
    fork
      do_req(0, 1, 0, 2'b00, 16'h0020, 16'h0000, o0);
      do_req(1, 0, 1, 2'b11, 16'h0020, 16'h1111, o1);
    join
    check("collide_read_old", 32'(o0), 32'h55CD);
    do_req(0, 1, 0, 2'b00, 16'h0020, 16'h0000, o0);
    check("collide_write_lands", 32'(o0), 32'h1111);

    // Same-edge double write: b owns the overlapping high byte
    fork
      do_req(0, 0, 1, 2'b11, 16'h0022, 16'hAB12, o0);
      do_req(1, 0, 1, 2'b10, 16'h0022, 16'hCD34, o1);
    join
    do_req(0, 1, 0, 2'b00, 16'h0022, 16'h0000, o0);
    check("double_write_b_wins", 32'(o0), 32'hCD12);

    // Read+write together acts as a write and returns the old word
    do_req(0, 1, 1, 2'b11, 16'h0022, 16'h4242, o0);
    check("rw_returns_old", 32'(o0), 32'hCD12);
    do_req(1, 1, 0, 2'b00, 16'h0022, 16'h0000, o1);
    check("rw_wrote", 32'(o1), 32'h4242);

    // Abort in the second WAIT cycle, then an aliased read of word 0
    do_req(1, 0, 1, 2'b11, 16'h0000, 16'hA5A5, o1);
    start_req(1, 1, 0, 2'b00, 16'h0040, 16'h0000);
    @(negedge clk);
    check("abort_wait1", 32'(if_b.mem_resp), 32'd0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    pend[1].valid = 1'b0;
    @(negedge clk);
    check("abort_no_resp", 32'(if_b.mem_resp), 32'd0);
    do_req(1, 1, 0, 2'b00, 16'h0200, 16'h0000, o1);
    check("alias_word0", 32'(o1), 32'hA5A5);

    // Reset during a pending write: it never lands
    do_req(1, 0, 1, 2'b11, 16'h0030, 16'h7777, o1);
    start_req(1, 0, 1, 2'b11, 16'h0030, 16'h9999);
    @(negedge clk);
    check("rst_mid_wait", 32'(if_b.mem_resp), 32'd0);
    reset = 1'b1;
    pend[1].valid = 1'b0;
    drive(1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    @(negedge clk);
    check("rst_mid_resp", 32'(if_b.mem_resp), 32'd0);
    check("rst_mid_rdata", 32'(if_b.mem_rdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_resp2", 32'(if_b.mem_resp), 32'd0);
    do_req(0, 1, 0, 2'b00, 16'h0030, 16'h0000, o0);
    check("rst_no_write", 32'(o0), 32'h7777);

    // Continuous reads: first after LATENCY, then every LATENCY+1
    drive(0, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000);
    t0 = cyc; nresp = 0; last = 0;
    for (int k = 1; k <= 4 * (LATENCY + 1); k++) begin
      @(negedge clk);
      if (if_a.mem_resp) begin
        if (nresp == 0) check("b2b_first", 32'(cyc - t0), 32'(LATENCY));
        else            check("b2b_period", 32'(cyc - last), 32'(LATENCY + 1));
        check("b2b_rdata", 32'(if_a.mem_rdata), 32'(ref_mem[widx(16'h0020)]));
        last = cyc;
        nresp++;
      end
    end
    drive(0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    check("b2b_count", 32'(nresp), 32'd4);
    @(negedge clk);

    // Randomized dual-port traffic against the reference memory
    for (int it = 0; it < 80; it++) begin
      fork
        rand_op(0);
        rand_op(1);
      join
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
